serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Directly consumes the half-subtractor stage: each bit slice is a full subtractor built from two half subtractors, with the borrow carried in a flip-flop between cycles.
- Sits between an operand producer and a result consumer; both sides use valid/ready handshakes.

Parameters:
- WIDTH, 8: operand and result width in bits; legal values are 2 and above.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned (two's complement when SERIAL_SUB_SIGNED_EN is defined).
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 exactly when a < b (unsigned).
- overflow  output  1  signed overflow flag; see Optional Feature.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - state=IDLE, in_ready=1, out_valid=0;
  - diff=0, borrow_out=0, overflow=0;
  - internal shift registers, borrow flip-flop and bit counter all to 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k: latch a and b into shift registers sa and sb, clear borrow_ff, clear counter, go to RUN.
- RUN:
  - in_ready=0 and out_valid=0; in_valid is ignored.
  - Each edge: d = sa[0]^sb[0]^borrow_ff; bout = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow_ff).
  - Shift d into the result MSB, shift sa and sb right, set borrow_ff=bout, counter += 1.
  - Counter width is clog2(WIDTH+1).
  - When the counter reaches WIDTH-1 at an edge, that edge processes the final bit, registers diff and borrow_out, and moves to DONE.
  - Result: out_valid rises after edge k+WIDTH, i.e. WIDTH cycles after input acceptance.
- DONE:
  - out_valid=1; diff, borrow_out and overflow are held stable.
  - On out_ready=1: go to IDLE with out_valid=0 next cycle.
  - out_ready low: results stay held indefinitely.
- Outputs diff, borrow_out and overflow keep the last result after returning to IDLE, until the next DONE.
- Throughput: in_ready is asserted only in IDLE, so back-to-back operations take WIDTH+2 cycles minimum.
- rst_n asserted mid-RUN or mid-DONE: the operation is aborted immediately and all outputs return to reset values. No partial result is ever presented.
- out_ready while not in DONE: ignored.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_EN.
- Defined: overflow is registered at the DONE transition as (a_msb != b_msb) && (diff_msb != a_msb). a_msb and b_msb are captured at input acceptance.
- Undefined: overflow is tied to 0, with no extra flops.
- The port list is identical in both builds.

Decomposition:
- Shared package serial_sub_pkg:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - WIDTH default constant;
  - counter-width function.
- Sub-module fs_cell (combinational full subtractor):
  - ports a, b, bin, d, bout;
  - built from two half-subtractor instances plus an OR of their borrows;
  - instantiated once and reused every cycle.

Test Plan:
- WIDTH=8, a=0x35, b=0x12 -> after 8 cycles out_valid=1, diff=0x23, borrow_out=0.
- a=0x12, b=0x35 -> diff=0xDD, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=b=0x00 -> diff=0x00, borrow_out=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff and out_valid stable, in_ready=0. out_ready=1 -> IDLE and in_ready=1 next cycle. Also pulse in_valid during RUN -> operands not captured.
- Pull rst_n low at RUN cycle 4 -> outputs go to 0 immediately, state IDLE. Next op a=0x0F, b=0x01 -> diff=0x0E, unaffected by the abort.
- With SERIAL_SUB_SIGNED_EN: a=0x80, b=0x01 -> diff=0x7F, overflow=1; a=0x05, b=0x03 -> overflow=0. Without the macro: overflow=0 for both.
- Random 1000 operand pairs with random out_ready stalls -> diff and borrow_out match the reference model {borrow,diff} = {1'b0,a} - {1'b0,b}.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor slice: FSM state
// encodings, the default operand width and the bit-counter width helper.
// Optional feature macro used by the design: SERIAL_SUB_SIGNED_EN
// (adds the registered signed-overflow flag).
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to hold WIDTH itself, hence clog2(WIDTH+1).
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// half_sub / fs_cell
// Combinational subtractor stages.
//   half_sub : a, b        -> d = a ^ b, bout = ~a & b
//   fs_cell  : a, b, bin   -> d = a ^ b ^ bin,
//                             bout = (~a & b) | (~(a ^ b) & bin)
// fs_cell is built from two half subtractors; the second one subtracts the
// incoming borrow from the first difference, and either stage may borrow.
module half_sub (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule

module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_sub hs1 (
    .a    (a),
    .b    (b),
    .d    (d1),
    .bout (b1)
  );

  half_sub hs2 (
    .a    (d1),
    .b    (bin),
    .d    (d),
    .bout (b2)
  );

  // The two half-subtractor borrows are never both set, so OR is exact.
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial WIDTH-bit subtractor, diff = a - b, one bit per clock, LSB
// first, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   a, b                  minuend / subtrahend
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   diff                  a - b modulo 2^WIDTH, held until the next result
//   borrow_out            1 when a < b (unsigned)
//   overflow              signed overflow, registered only when
//                         SERIAL_SUB_SIGNED_EN is defined, otherwise 0
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  // Holds the WIDTH-1 low result bits; the final bit is appended on the
  // last RUN edge straight into diff_q.
  logic [WIDTH-2:0] res_q;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrowOut_q;

  logic             bitD;
  logic             bitBout;
  logic [WIDTH-1:0] resNext;
  logic             accept;
  logic             lastBit;

  fs_cell u_fs (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (borrow_q),
    .d    (bitD),
    .bout (bitBout)
  );

  assign resNext = {bitD, res_q};
  assign accept  = (state_q == IDLE) && in_valid;
  assign lastBit = (state_q == RUN) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (lastBit)   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath: operand capture, per-bit shift and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      borrowOut_q <= 1'b0;
    end else if (accept) begin
      sa_q     <= a;
      sb_q     <= b;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      sa_q     <= {1'b0, sa_q[WIDTH-1:1]};
      sb_q     <= {1'b0, sb_q[WIDTH-1:1]};
      res_q    <= resNext[WIDTH-1:1];
      borrow_q <= bitBout;
      cnt_q    <= cnt_q + CNT_ONE;
      if (lastBit) begin
        diff_q      <= resNext;
        borrowOut_q <= bitBout;
      end
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrowOut_q;

`ifdef SERIAL_SUB_SIGNED_EN
  logic aMsb_q;
  logic bMsb_q;
  logic overflow_q;

  // Operand sign bits are kept separately because the shift registers lose
  // them; on the last edge bitD is the result sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aMsb_q     <= 1'b0;
      bMsb_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      aMsb_q <= a[WIDTH-1];
      bMsb_q <= b[WIDTH-1];
    end else if (lastBit) begin
      overflow_q <= (aMsb_q != bMsb_q) && (bitD != aMsb_q);
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results are
// pushed when operands are accepted and popped when a result is consumed.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int TIMEOUT = 50;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: unsigned borrow/difference plus signed overflow.
  function automatic exp_t model(input logic [W-1:0] opA, input logic [W-1:0] opB);
    exp_t e;
    logic [W:0] full;
    full     = {1'b0, opA} - {1'b0, opB};
    e.diff   = full[W-1:0];
    e.borrow = full[W];
`ifdef SERIAL_SUB_SIGNED_EN
    e.ovf    = (opA[W-1] != opB[W-1]) && (full[W-1] != opA[W-1]);
`else
    e.ovf    = 1'b0;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one operation end to end: handshake in, optional in_valid pulse
  // during RUN, latency check, optional out_ready stall, scoreboard compare.
  task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                               input int stall, input bit pulseInRun);
    exp_t e;
    exp_t got;
    int   cycles;
    @(negedge clk);
    checkOutput("inReadyIdle", in_ready, 1);
    a        = opA;
    b        = opB;
    in_valid = 1'b1;
    @(posedge clk);
    expQ.push_back(model(opA, opB));
    @(negedge clk);
    in_valid = 1'b0;
    cycles   = 0;
    while (!out_valid && cycles < TIMEOUT) begin
      if (pulseInRun && cycles == 2) begin
        a        = ~opA;
        b        = ~opB;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    checkOutput("latency", cycles, W);
    if (!out_valid) return;
    e = expQ[0];
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("stallValid", out_valid, 1);
      checkOutput("stallInReady", in_ready, 0);
      checkOutput("stallDiff", diff, e.diff);
    end
    out_ready = 1'b1;
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 0, 1);
    end else begin
      got.diff   = diff;
      got.borrow = borrow_out;
      got.ovf    = overflow;
      e          = expQ.pop_front();
      checkOutput("diff", got.diff, e.diff);
      checkOutput("borrow", got.borrow, e.borrow);
      checkOutput("overflow", got.ovf, e.ovf);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("idleValid", out_valid, 0);
    checkOutput("idleReady", in_ready, 1);
    checkOutput("heldDiff", diff, e.diff);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    checkOutput("rstInReady", in_ready, 1);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstDiff", diff, 0);
    checkOutput("rstBorrow", borrow_out, 0);
    checkOutput("rstOverflow", overflow, 0);
    rst_n = 1'b1;

    applyStimulus(8'h35, 8'h12, 0, 1'b0);
    applyStimulus(8'h12, 8'h35, 0, 1'b0);
    applyStimulus(8'h00, 8'h01, 0, 1'b0);
    applyStimulus(8'h00, 8'h00, 0, 1'b0);
    applyStimulus(8'h5A, 8'h21, 5, 1'b1);
    applyStimulus(8'h80, 8'h01, 0, 1'b0);
    applyStimulus(8'h05, 8'h03, 0, 1'b0);
    applyStimulus(8'h7F, 8'hFF, 1, 1'b0);

    // Abort mid-RUN: previous result (nonzero) must vanish with reset.
    @(negedge clk);
    a        = 8'h55;
    b        = 8'h11;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abortOutValid", out_valid, 0);
    checkOutput("abortInReady", in_ready, 1);
    checkOutput("abortDiff", diff, 0);
    checkOutput("abortBorrow", borrow_out, 0);
    checkOutput("abortOverflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h0F, 8'h01, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           st;
      ra = W'($urandom);
      rb = W'($urandom);
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      applyStimulus(ra, rb, st, 1'b0);
    end

    checkOutput("queueDrained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
